// File: rtl/imem_pkg.sv
// Shared constants for the instruction memory, its fetch stage and its loader.
package imem_pkg;

    localparam logic [31:0] INIT_PC        = 32'h0000_3000;
    localparam int unsigned DEPTH          = 1024;
    localparam int unsigned LEN_W          = 11;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_wr_t;

    // Byte address of word idx relative to base; plain 32-bit add, wraps silently.
    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                    input logic [WORD_W-1:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// 8->32 shift assembler, MSB-first, with a byte counter. word_c/word_full_c show the
// word as it will be once the current shift lands, so the caller can register it directly.
module imem_byte_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift,
    input  logic              clear,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] word_c,
    output logic              word_full_c
);

    logic [WORD_W-1:0]     asm_q;
    logic [BYTE_IDX_W-1:0] byte_idx_q;

    assign word_c      = {asm_q[WORD_W-BYTE_W-1:0], data};
    assign word_full_c = shift && (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    // The counter wraps to 0 on the fourth shift, ready for the next word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_q      <= '0;
            byte_idx_q <= '0;
        end else if (clear) begin
            asm_q      <= '0;
            byte_idx_q <= '0;
        end else if (shift) begin
            asm_q      <= word_c;
            byte_idx_q <= byte_idx_q + BYTE_IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Packs an incoming byte stream into instruction words and writes them sequentially
// from INIT_PC, holding the core off for the duration of the load.
module imem_loader
    import imem_pkg::*;
#(
    parameter logic [31:0] INIT_PC = imem_pkg::INIT_PC,
    parameter int unsigned DEPTH   = imem_pkg::DEPTH,
    parameter int unsigned LEN_W   = imem_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] word_count,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    state_t           state_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] word_idx_q;
    mem_wr_t          wr_q;
    logic             byte_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic              transfer_c;
    logic              start_ok_c;
    logic [WORD_W-1:0] word_c;
    logic              word_full_c;

    assign transfer_c = byte_valid && byte_ready_q;
    assign start_ok_c = (state_q == ST_IDLE) && start && (word_count != '0)
                        && (word_count <= LEN_W'(DEPTH));

    imem_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift       (transfer_c),
        .clear       (start_ok_c),
        .data        (byte_data),
        .word_c      (word_c),
        .word_full_c (word_full_c)
    );

    // Control FSM; every output is a flop updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            word_idx_q   <= '0;
            wr_q         <= '0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            wr_q.we <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (word_count > LEN_W'(DEPTH)) begin
                            error_q <= 1'b1;
                        end else begin
                            count_q      <= word_count;
                            word_idx_q   <= '0;
                            state_q      <= ST_COLLECT;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (word_full_c) begin
                        state_q      <= ST_WRITE;
                        byte_ready_q <= 1'b0;
                        wr_q.we      <= 1'b1;
                        wr_q.addr    <= word_addr(INIT_PC, WORD_W'(word_idx_q));
                        wr_q.wdata   <= word_c;
                    end
                end
                ST_WRITE: begin
                    if (word_idx_q == count_q - LEN_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        word_idx_q   <= word_idx_q + LEN_W'(1);
                        state_q      <= ST_COLLECT;
                        byte_ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = wr_q.we;
    assign mem_addr   = wr_q.addr;
    assign mem_wdata  = wr_q.wdata;
    assign busy       = busy_q;
    assign cpu_hold   = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a write-queue model built from the byte image,
// checked on every cycle, plus literal expectations for the worked examples.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_3000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] word_count = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, mem_we, busy, cpu_hold, done, error;
    logic [31:0] mem_addr, mem_wdata;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_we_cyc = -1;
    int   last_done_cyc = -1;
    logic busy_at_done = 1'b1;
    int   n_done = 0;
    int   n_err = 0;
    wr_t  exp_q[$];
    wr_t  wr_log[$];
    logic [7:0] img [0:4095];

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the expected write queue.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        chk("cpu_hold_eq_busy", 32'(cpu_hold), 32'(busy));
        if (mem_we) begin
            wr_log.push_back('{mem_addr, mem_wdata});
            last_we_cyc = cyc;
            chk("no_ready_in_write", 32'(byte_ready), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
            end
        end
        if (done) begin
            n_done++;
            last_done_cyc = cyc;
            busy_at_done = busy;
        end
        if (error) n_err++;
    end

    task automatic pulse_start(input int wc);
        start = 1'b1;
        word_count = 11'(wc);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stray);
        int guard = 0;
        byte_valid = 1'b1;
        byte_data = b;
        if (stray) start = 1'b1;
        forever begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk); #1;
                break;
            end
            guard++;
            if (guard > 50) begin
                chk("byte_accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        logic seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        #1;
    endtask

    // Model: word i of the image is the big-endian concatenation of bytes 4i..4i+3.
    task automatic push_expect(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{BASE + 32'(4 * i),
                              {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]}});
    endtask

    task automatic run_load(input int n, input logic gap, input logic stray);
        pulse_start(n);
        push_expect(n);
        for (int k = 0; k < 4 * n; k++) begin
            send_byte(img[k], stray && (k % 37 == 5));
            if (gap) begin
                @(posedge clk); #1;
            end
        end
        wait_done(20);
        @(posedge clk); #1;
    endtask

    initial begin
        int base, d0;
        logic [7:0] pat [0:7];
        pat = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h12, 8'h34};

        // 1: reset, then idle with byte_valid high
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", 32'({byte_ready, mem_we, busy, cpu_hold, done, error}), 32'd0);
        end
        chk("idle_addr", mem_addr, 32'd0);
        chk("idle_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        byte_valid = 1'b0;

        // 2: two words back-to-back
        for (int i = 0; i < 8; i++) img[i] = pat[i];
        base = wr_log.size();
        d0 = n_done;
        run_load(2, 1'b0, 1'b0);
        chk("t2_writes", 32'(wr_log.size() - base), 32'd2);
        if (wr_log.size() >= base + 2) begin
            chk("t2_addr0", wr_log[base].addr, 32'h0000_3000);
            chk("t2_data0", wr_log[base].data, 32'h2008_0005);
            chk("t2_addr1", wr_log[base+1].addr, 32'h0000_3004);
            chk("t2_data1", wr_log[base+1].data, 32'h3C01_1234);
        end
        chk("t2_done_latency", 32'(last_done_cyc - last_we_cyc), 32'd1);
        chk("t2_busy_at_done", 32'(busy_at_done), 32'd0);
        chk("t2_done_count", 32'(n_done - d0), 32'd1);

        // 3: same load, byte_valid toggling
        base = wr_log.size();
        run_load(2, 1'b1, 1'b0);
        chk("t3_writes", 32'(wr_log.size() - base), 32'd2);
        if (wr_log.size() >= base + 2)
            chk("t3_data1", wr_log[base+1].data, 32'h3C01_1234);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4: zero-length and oversize requests
        base = wr_log.size();
        pulse_start(0);
        @(negedge clk);
        chk("t4_done_zero", 32'(done), 32'd1);
        chk("t4_busy_zero", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_done_single", 32'(done), 32'd0);
        @(posedge clk); #1;
        pulse_start(1025);
        @(negedge clk);
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_busy_err", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_error_single", 32'(error), 32'd0);
        chk("t4_busy_err2", 32'(busy), 32'd0);
        chk("t4_no_writes", 32'(wr_log.size() - base), 32'd0);
        chk("t4_err_count", 32'(n_err), 32'd1);
        @(posedge clk); #1;

        // 5: reset mid-word
        for (int i = 0; i < 8; i++) img[i] = 8'(8'h40 + i);
        pulse_start(2);
        push_expect(1);
        for (int k = 0; k < 6; k++) send_byte(img[k], 1'b0);
        base = wr_log.size();
        d0 = n_done;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_no_write", 32'(wr_log.size() - base), 32'd0);
        chk("t5_no_done", 32'(n_done - d0), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        img[0] = 8'hDE; img[1] = 8'hAD; img[2] = 8'hBE; img[3] = 8'hEF;
        base = wr_log.size();
        run_load(1, 1'b0, 1'b0);
        chk("t5_reload_writes", 32'(wr_log.size() - base), 32'd1);
        if (wr_log.size() > base) begin
            chk("t5_reload_addr", wr_log[base].addr, 32'h0000_3000);
            chk("t5_reload_data", wr_log[base].data, 32'hDEAD_BEEF);
        end

        // 6: full-depth load with stray start pulses
        for (int i = 0; i < 4096; i++) img[i] = 8'($urandom_range(0, 255));
        base = wr_log.size();
        d0 = n_done;
        run_load(1024, 1'b0, 1'b1);
        chk("t6_writes", 32'(wr_log.size() - base), 32'd1024);
        if (wr_log.size() > 0)
            chk("t6_last_addr", wr_log[wr_log.size()-1].addr, 32'h0000_3FFC);
        chk("t6_done_count", 32'(n_done - d0), 32'd1);
        chk("t6_no_error", 32'(n_err), 32'd1);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_idle_after", 32'({byte_ready, busy, done, mem_we}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
